// File: rtl/simmem_pkg.sv
// Shared constants and types for the simulated-memory read-data path.
package simmem_pkg;

  localparam int unsigned NumIds        = 4;
  localparam int unsigned MaxRBurstLenW = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } rdata_arb_state_e;

endpackage

// File: rtl/simmem_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping from N-1 back to 0.
module simmem_rr_picker #(
  parameter int unsigned N    = 4,
  parameter int unsigned PtrW = 2
) (
  input  logic [N-1:0]    req_i,
  input  logic [PtrW-1:0] ptr_i,
  output logic [N-1:0]    pick_o,
  output logic            found_o
);

  // Scan offsets 0..N-1 from the pointer and keep the first hit.
  always_comb begin
    int unsigned idx;
    pick_o  = '0;
    found_o = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!found_o && (i == idx) && req_i[i]) begin
          pick_o[i] = 1'b1;
          found_o   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/simmem_rdata_arbiter.sv
// Read-data arbiter: round-robin between per-ID head beats, holding the
// grant for the whole burst once it starts.
// Optional: define SIMMEM_RDATA_ARB_STATS_EN to add stall_cnt_o, a
// saturating count of cycles with a beat presented but not accepted.
module simmem_rdata_arbiter
  import simmem_pkg::*;
#(
  parameter int unsigned NumIds    = simmem_pkg::NumIds,
  parameter int unsigned BurstLenW = simmem_pkg::MaxRBurstLenW
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NumIds-1:0]           req_valid_i,
  input  logic [NumIds*BurstLenW-1:0] req_burst_len_i,
  output logic [NumIds-1:0]           req_ready_o,
  output logic [NumIds-1:0]           grant_onehot_o,
  output logic                        out_valid_o,
  input  logic                        out_ready_i,
  output logic                        out_last_o
`ifdef SIMMEM_RDATA_ARB_STATS_EN
  ,
  output logic [31:0]                 stall_cnt_o
`endif
);

  localparam int unsigned IdW  = (NumIds > 1) ? $clog2(NumIds) : 1;
  localparam int unsigned CntW = BurstLenW + 1;

  rdata_arb_state_e       state_q, state_d;
  logic [IdW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]         lock_id_q, lock_id_d;
  logic [CntW-1:0]        beat_cnt_q, beat_cnt_d;

  logic [NumIds-1:0]      pick_oh;
  logic                   pick_found;
  logic [NumIds-1:0]      grant_oh;
  logic [IdW-1:0]         grant_idx;
  logic [BurstLenW-1:0]   grant_len;
  logic                   grant_valid;
  logic                   hs;

  simmem_rr_picker #(
    .N    (NumIds),
    .PtrW (IdW)
  ) u_picker (
    .req_i   (req_valid_i),
    .ptr_i   (rr_ptr_q),
    .pick_o  (pick_oh),
    .found_o (pick_found)
  );

  // Resolve the current grant: fresh pick in IDLE, held ID while LOCKED.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_len = '0;
    if (state_q == IDLE) begin
      grant_oh = pick_oh;
    end else begin
      for (int unsigned i = 0; i < NumIds; i++) begin
        grant_oh[i] = (lock_id_q == IdW'(i));
      end
    end
    for (int unsigned i = 0; i < NumIds; i++) begin
      if (grant_oh[i]) begin
        grant_idx = IdW'(i);
        grant_len = req_burst_len_i[i*BurstLenW +: BurstLenW];
      end
    end
    grant_valid = |(req_valid_i & grant_oh);
    hs          = grant_valid & out_ready_i;
  end

  // State register and burst bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lock_id_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_id_q  <= lock_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Next state: lock on any grant that is not a completed single beat.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lock_id_d  = lock_id_q;
    beat_cnt_d = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          if (hs && (grant_len == '0)) begin
            rr_ptr_d = (grant_idx == IdW'(NumIds - 1)) ? '0 : grant_idx + IdW'(1);
          end else begin
            state_d    = LOCKED;
            lock_id_d  = grant_idx;
            // A beat taken this cycle leaves len beats; otherwise all len+1 remain.
            beat_cnt_d = hs ? {1'b0, grant_len} : ({1'b0, grant_len} + CntW'(1));
          end
        end
      end
      LOCKED: begin
        if (hs) begin
          beat_cnt_d = beat_cnt_q - CntW'(1);
          if (beat_cnt_q == CntW'(1)) begin
            state_d  = IDLE;
            rr_ptr_d = (lock_id_q == IdW'(NumIds - 1)) ? '0 : lock_id_q + IdW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs toward the bank queues and downstream.
  always_comb begin
    grant_onehot_o = grant_oh;
    req_ready_o    = grant_oh & {NumIds{out_ready_i}};
    out_valid_o    = grant_valid;
    if (state_q == IDLE) begin
      out_last_o = pick_found && (grant_len == '0);
    end else begin
      out_last_o = (beat_cnt_q == CntW'(1));
    end
  end

`ifdef SIMMEM_RDATA_ARB_STATS_EN
  logic [31:0] stall_cnt_q;

  // Saturating count of presented-but-not-accepted cycles.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (grant_valid && !out_ready_i && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`endif

endmodule
